bird_motion: RTL and testbench
==============================

Name: bird_motion

Overview:
- Parametrised next-generation bird controller for the Flappy Bird VGA game.
- Replaces the fixed-step flap/gravity scheme with signed-velocity physics: gravity accumulation, flap impulse, terminal velocity and ceiling/floor clamping.
- Adds an explicit game-state FSM, an N-frame animation sequencer, and a registered sprite-ROM address and hit mask for the pixel at (col,row).
- Sits between the game top (playing, flap, VGA scan coordinates) and the external sprite ROMs and collision logic.

Parameters:
- SPR_W, 48, sprite width in pixels
- SPR_H, 34, sprite height in pixels
- INI_X, 35, bird top-left x
- INI_Y, 192, bird top-left y after reset/idle
- Y_MAX, 446, lowest legal top-left y (480-SPR_H); reaching it is a floor hit
- GRAVITY, 1, velocity increment per physics tick
- FLAP_VEL, 7, upward speed loaded on flap (velocity becomes -FLAP_VEL)
- VMAX, 8, terminal downward velocity
- FRAMES, 3, animation frame count
- FRAME_TICKS, 16, physics ticks per animation frame
- ADDR_W, 11, sprite ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  physics-step strobe, one clk wide
- playing  in  1  game running level
- flap  in  1  flap button level, already synchronised
- col  in  10  current scan column
- row  in  9  current scan row
- bird_x  out  10  top-left x
- bird_y  out  9  top-left y
- vel  out  5  signed velocity, pixels per tick
- state  out  2  0 IDLE, 1 FLY, 2 DEAD
- hit_floor  out  1  high in DEAD
- frame_sel  out  2  animation frame index, 0..FRAMES-1
- sprite_addr  out  ADDR_W  ROM address for (col,row)
- in_sprite  out  1  (col,row) inside the sprite box
- tilt  out  2  sprite tilt class

Behaviour:
- Reset values: bird_x=INI_X, bird_y=INI_Y, vel=0, state=IDLE, hit_floor=0, frame_sel=0, sprite_addr=0, in_sprite=0, tilt=1, tick counter=0, flap_q=0, flap_pend=0.
- Flap edge detection:
  - flap_q is a registered copy of flap.
  - A rising edge (flap & ~flap_q) sets flap_pend; holding the button yields only one impulse.
  - flap_pend clears on the next tick consumed in FLY, and in IDLE/DEAD.
  - An edge coinciding with a tick counts for that tick.
- playing low in any state: next clk state=IDLE, bird_y=INI_Y, vel=0, hit_floor=0. bird_x is constant INI_X.
- IDLE:
  - position held; frame sequencer runs.
  - playing high: FLY on the next clk, vel=0.
- FLY, on tick:
  - If flap_pend: vel_n = -FLAP_VEL; else vel_n = min(vel+GRAVITY, VMAX).
  - y_n = bird_y + vel_n, computed 11-bit signed.
  - If y_n < 0: bird_y=0, vel=0 (ceiling clamp, no death).
  - If y_n >= Y_MAX: bird_y=Y_MAX, vel=0, state=DEAD.
  - Otherwise: bird_y=y_n, vel=vel_n.
  - No tick: all physics state held.
- DEAD: position and frame frozen, hit_floor=1, flap ignored; leaves only via playing low.
- Animation:
  - A tick counter counts ticks in IDLE/FLY.
  - At FRAME_TICKS-1 the counter clears and frame_sel advances, wrapping FRAMES-1 to 0.
- Pixel path, one clk latency from col/row:
  - dx = col - bird_x, dy = row - bird_y.
  - in_sprite = (col >= bird_x) && (dx < SPR_W) && (row >= bird_y) && (dy < SPR_H).
  - sprite_addr = dy*SPR_W + dx when inside, else 0.
  - Position used is the value registered at that clk.
- tilt: 1.

Optional Feature:
- Macro BIRD_TILT_EN.
- Defined: tilt is registered on tick: 0 if vel<0, 2 if vel >= VMAX/2, else 1. Tilt is frozen in DEAD and is 1 in IDLE.
- Undefined: tilt tied to 1 and no tilt logic is generated.

Decomposition:
- Shared package/header bird_pkg holds:
  - state encodings ST_IDLE/ST_FLY/ST_DEAD
  - default geometry (SPR_W, SPR_H, INI_X, INI_Y, screen 640x480)
  - physics defaults (GRAVITY, FLAP_VEL, VMAX)
- One natural sub-module: bird_pix_addr, the registered box test and address multiply. It is reused later for pipe sprites.

Test Plan:
- Reset then playing=1, no flap, 10 ticks -> vel 1,2,…,8,8,8; bird_y = 192 + (1+…+8+8+8) = 244.
- In FLY at y=100, flap pulse 1 clk then tick -> vel=-7, bird_y=93. Flap held 20 ticks -> exactly one impulse.
- At y=3, vel=-7, tick -> bird_y=0, vel=0, state stays FLY.
- Free-fall until y_n >= 446 -> bird_y=446, state=DEAD, hit_floor=1. Further ticks and flaps change nothing. Then playing=0 -> IDLE, y=192, hit_floor=0.
- Bird at (35,192): col=35,row=192 -> next clk in_sprite=1, addr=0. col=82,row=225 -> addr=1631. col=83 -> in_sprite=0, addr=0.
- FRAME_TICKS=16, FRAMES=3: 48 ticks in IDLE -> frame_sel 0→1→2→0. Assert rst_n low mid-sequence -> all outputs at reset values immediately, with no clk edge.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared encodings and default geometry/physics for the bird controller
// and the sprite pixel-address helper.
package bird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_SPR_W = 48;
  localparam int DEF_SPR_H = 34;
  localparam int DEF_INI_X = 35;
  localparam int DEF_INI_Y = 192;
  localparam int DEF_Y_MAX = SCREEN_H - DEF_SPR_H;

  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = 7;
  localparam int DEF_VMAX     = 8;

  localparam int DEF_FRAMES      = 3;
  localparam int DEF_FRAME_TICKS = 16;
  localparam int DEF_ADDR_W      = 11;

  localparam logic [1:0] TILT_UP    = 2'd0;
  localparam logic [1:0] TILT_LEVEL = 2'd1;
  localparam logic [1:0] TILT_DOWN  = 2'd2;

endpackage

// File: rtl/bird_motion_if.sv
// Bundle between the game top (master) and the bird controller (slave).
interface bird_motion_if
  import bird_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  // No handshake: tick is a one-clk strobe that is always accepted; the
  // other inputs are levels and every output is valid on every clk.
  logic              tick;
  logic              playing;
  logic              flap;
  logic [9:0]        col;
  logic [8:0]        row;

  logic [9:0]        bird_x;
  logic [8:0]        bird_y;
  logic signed [4:0] vel;
  state_t            state;
  logic              hit_floor;
  logic [1:0]        frame_sel;
  logic [ADDR_W-1:0] sprite_addr;
  logic              in_sprite;
  logic [1:0]        tilt;

  modport master (
    output tick, playing, flap, col, row,
    input  bird_x, bird_y, vel, state, hit_floor, frame_sel,
           sprite_addr, in_sprite, tilt
  );

  modport slave (
    input  tick, playing, flap, col, row,
    output bird_x, bird_y, vel, state, hit_floor, frame_sel,
           sprite_addr, in_sprite, tilt
  );

endinterface

// File: rtl/bird_pix_addr.sv
// Registered sprite box test and linear ROM address for the scan pixel.
// Generic over sprite size so it can serve other sprites (pipes).
module bird_pix_addr
  import bird_pkg::*;
#(
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        col,
  input  logic [8:0]        row,
  input  logic [9:0]        pos_x,
  input  logic [8:0]        pos_y,
  output logic              in_box,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [9:0] W_L = 10'(SPR_W);
  localparam logic [8:0] H_L = 9'(SPR_H);

  logic [9:0]        dx;
  logic [8:0]        dy;
  logic              hit;
  logic [ADDR_W-1:0] lin;

  // dx/dy wrap when the pixel is left of / above the box, hence the >= guards.
  always_comb begin
    dx  = col - pos_x;
    dy  = row - pos_y;
    hit = (col >= pos_x) && (dx < W_L) && (row >= pos_y) && (dy < H_L);
    lin = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box <= 1'b0;
      addr   <= '0;
    end else begin
      in_box <= hit;
      addr   <= hit ? lin : '0;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird controller: game-state FSM, signed-velocity physics, animation frame
// sequencer and sprite pixel addressing. Optional tilt class: BIRD_TILT_EN.
module bird_motion
  import bird_pkg::*;
#(
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int INI_X       = DEF_INI_X,
  parameter int INI_Y       = DEF_INI_Y,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int FLAP_VEL    = DEF_FLAP_VEL,
  parameter int VMAX        = DEF_VMAX,
  parameter int FRAMES      = DEF_FRAMES,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  bird_motion_if.slave  bus
);

  localparam int CNT_W = $clog2(FRAME_TICKS);

  localparam logic [8:0]         INI_Y_L    = 9'(INI_Y);
  localparam logic [8:0]         Y_MAX_L    = 9'(Y_MAX);
  localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
  localparam logic signed [4:0]  FLAP_V_L   = 5'(-FLAP_VEL);
  localparam logic signed [5:0]  GRAV_L     = 6'(GRAVITY);
  localparam logic signed [5:0]  VMAX_S6    = 6'(VMAX);
  localparam logic signed [4:0]  VMAX_S5    = 5'(VMAX);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [1:0]         FRAME_LAST = 2'(FRAMES - 1);

  state_t             state_q, state_d;
  logic [8:0]         y_q, y_d;
  logic signed [4:0]  vel_q, vel_d;
  logic               flap_q;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         frame_q, frame_d;

  logic               flap_edge;
  logic signed [5:0]  vsum;
  logic signed [4:0]  vel_n;
  logic signed [10:0] y_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= INI_Y_L;
      vel_q   <= '0;
      flap_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      flap_q  <= bus.flap;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;

    flap_edge = bus.flap & ~flap_q;
    vsum      = $signed({vel_q[4], vel_q}) + GRAV_L;
    // An edge arriving in the same clk as the tick still counts for it.
    if (pend_q || flap_edge)
      vel_n = FLAP_V_L;
    else if (vsum > VMAX_S6)
      vel_n = VMAX_S5;
    else
      vel_n = vsum[4:0];
    y_n = $signed({2'b00, y_q}) + $signed({{6{vel_n[4]}}, vel_n});

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (bus.playing) begin
          state_d = ST_FLY;
          vel_d   = '0;
        end
      end
      ST_FLY: begin
        if (bus.tick) begin
          pend_d = 1'b0;
          if (y_n[10]) begin
            y_d   = '0;
            vel_d = '0;
          end else if (y_n >= Y_MAX_S) begin
            y_d     = Y_MAX_L;
            vel_d   = '0;
            state_d = ST_DEAD;
          end else begin
            y_d   = y_n[8:0];
            vel_d = vel_n;
          end
        end else begin
          pend_d = pend_q | flap_edge;
        end
      end
      ST_DEAD: pend_d = 1'b0;
      default: state_d = ST_IDLE;
    endcase

    if (bus.tick && (state_q != ST_DEAD)) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        frame_d = (frame_q == FRAME_LAST) ? 2'd0 : frame_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Dropping playing wins over everything above, from any state.
    if (!bus.playing) begin
      state_d = ST_IDLE;
      y_d     = INI_Y_L;
      vel_d   = '0;
      pend_d  = 1'b0;
    end
  end

  assign bus.bird_x    = 10'(INI_X);
  assign bus.bird_y    = y_q;
  assign bus.vel       = vel_q;
  assign bus.state     = state_q;
  assign bus.hit_floor = (state_q == ST_DEAD);
  assign bus.frame_sel = frame_q;

`ifdef BIRD_TILT_EN
  localparam logic signed [4:0] VHALF_L = 5'(VMAX / 2);
  logic [1:0] tilt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tilt_q <= TILT_LEVEL;
    else if (!bus.playing || state_q == ST_IDLE)
      tilt_q <= TILT_LEVEL;
    else if (state_q == ST_FLY && bus.tick)
      tilt_q <= (vel_d < 0) ? TILT_UP : ((vel_d >= VHALF_L) ? TILT_DOWN : TILT_LEVEL);
  end

  assign bus.tilt = tilt_q;
`else
  assign bus.tilt = TILT_LEVEL;
`endif

  bird_pix_addr #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ADDR_W (ADDR_W)
  ) u_pix (
    .clk    (clk),
    .rst_n  (rst_n),
    .col    (bus.col),
    .row    (bus.row),
    .pos_x  (10'(INI_X)),
    .pos_y  (y_q),
    .in_box (bus.in_sprite),
    .addr   (bus.sprite_addr)
  );

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: physics per tick, ceiling/floor, DEAD,
// pixel addressing, animation frames and asynchronous reset.
module tb_bird_motion;
  import bird_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bird_motion_if #(.ADDR_W(11)) bus();

  bird_motion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] exp_q[$];
  logic [11:0] pix_q[$];
  logic        pix_v;
  logic [15:0] mon_e;
  logic [11:0] mon_p;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ph(input int st, input int y, input int v);
    return {2'(st), 9'(y), 5'(v)};
  endfunction

  // Physics monitor: every accepted tick has one expectation queued.
  always @(posedge clk) begin
    if (rst_n && bus.tick) begin
      #1;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL phys_unexpected: tick with empty expected queue");
      end else begin
        mon_e = exp_q.pop_front();
        chk("phys_state", int'(bus.state), int'(mon_e[15:14]));
        chk("phys_y", int'(bus.bird_y), int'(mon_e[13:5]));
        chk("phys_vel", int'(bus.vel), int'($signed(mon_e[4:0])));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && pix_v) begin
      #1;
      if (pix_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL pix_unexpected: request with empty expected queue");
      end else begin
        mon_p = pix_q.pop_front();
        chk("pix_in", int'(bus.in_sprite), int'(mon_p[11]));
        chk("pix_addr", int'(bus.sprite_addr), int'(mon_p[10:0]));
      end
    end
  end

  task automatic do_tick(input int st, input int y, input int v);
    @(negedge clk);
    exp_q.push_back(ph(st, y, v));
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic flap_tick(input int st, input int y, input int v);
    @(negedge clk);
    exp_q.push_back(ph(st, y, v));
    bus.tick = 1'b1;
    bus.flap = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    bus.flap = 1'b0;
  endtask

  task automatic pix(input int c, input int r, input int in_exp, input int a_exp);
    @(negedge clk);
    bus.col = 10'(c);
    bus.row = 9'(r);
    pix_q.push_back({1'(in_exp), 11'(a_exp)});
    pix_v = 1'b1;
    @(negedge clk);
    pix_v = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || pix_q.size() != 0); i++)
      @(negedge clk);
    if (exp_q.size() != 0 || pix_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d phys and %0d pix expectations left", exp_q.size(), pix_q.size());
      exp_q.delete();
      pix_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, int'(bus.bird_x), 35);
    chk({tag, "_y"}, int'(bus.bird_y), 192);
    chk({tag, "_vel"}, int'(bus.vel), 0);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_hit"}, int'(bus.hit_floor), 0);
    chk({tag, "_frame"}, int'(bus.frame_sel), 0);
    chk({tag, "_addr"}, int'(bus.sprite_addr), 0);
    chk({tag, "_in"}, int'(bus.in_sprite), 0);
    chk({tag, "_tilt"}, int'(bus.tilt), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ya[10] = '{193, 195, 198, 202, 207, 213, 220, 228, 236, 244};
  int va[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
  int yb[20] = '{230, 224, 219, 215, 212, 210, 209, 209, 210, 212,
                 215, 219, 224, 230, 237, 245, 253, 261, 269, 277};
  int vb[20] = '{-7, -6, -5, -4, -3, -2, -1, 0, 1, 2,
                 3, 4, 5, 6, 7, 8, 8, 8, 8, 8};

  initial begin
    bus.tick = 1'b0; bus.playing = 1'b0; bus.flap = 1'b0;
    bus.col = '0; bus.row = '0; pix_v = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst");

    // Gravity ramp to terminal velocity.
    bus.playing = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("fly_state", int'(bus.state), 1);
    for (int i = 0; i < 10; i++) do_tick(1, ya[i], va[i]);
    drain();

    // Single flap pulse, then a held button gives exactly one impulse.
    @(negedge clk); bus.flap = 1'b1;
    @(negedge clk); bus.flap = 1'b0;
    do_tick(1, 237, -7);
    bus.flap = 1'b1;
    for (int i = 0; i < 20; i++) do_tick(1, yb[i], vb[i]);
    bus.flap = 1'b0;
    drain();

    // Flap edges coinciding with ticks, climbing into the ceiling clamp.
    for (int k = 1; k <= 39; k++) flap_tick(1, 277 - 7 * k, -7);
    flap_tick(1, 0, 0);
    drain();

    // Free fall to the floor, then DEAD ignores ticks and flaps.
    for (int i = 1; i <= 8; i++) do_tick(1, i * (i + 1) / 2, i);
    for (int m = 1; m <= 51; m++) do_tick(1, 36 + 8 * m, 8);
    do_tick(2, 446, 0);
    for (int i = 0; i < 3; i++) flap_tick(2, 446, 0);
    drain();
    chk("dead_hit", int'(bus.hit_floor), 1);
    chk("dead_frame", int'(bus.frame_sel), 2);

    bus.playing = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("idle_state", int'(bus.state), 0);
    chk("idle_y", int'(bus.bird_y), 192);
    chk("idle_vel", int'(bus.vel), 0);
    chk("idle_hit", int'(bus.hit_floor), 0);

    // Pixel box edges with the bird at (35,192).
    pix(35, 192, 1, 0);
    pix(82, 225, 1, 1631);
    pix(83, 225, 0, 0);
    pix(34, 200, 0, 0);
    pix(50, 200, 1, 399);
    pix(40, 226, 0, 0);
    drain();

    // Move away from reset values, then drop rst_n between clock edges.
    bus.playing = 1'b1;
    @(negedge clk); @(negedge clk);
    do_tick(1, 193, 1);
    do_tick(1, 195, 2);
    do_tick(1, 198, 3);
    do_tick(1, 202, 4);
    do_tick(1, 207, 5);
    drain();
    bus.col = 10'd50;
    bus.row = 9'd215;
    @(negedge clk);
    chk("pre_rst_addr", int'(bus.sprite_addr), 399);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    bus.playing = 1'b0;
    bus.col = '0;
    bus.row = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Frame sequencer in IDLE: 16 ticks per frame, wrapping after 3.
    for (int i = 0; i < 48; i++) begin
      do_tick(0, 192, 0);
      if (i == 14) chk("frame_t15", int'(bus.frame_sel), 0);
      if (i == 15) chk("frame_t16", int'(bus.frame_sel), 1);
      if (i == 31) chk("frame_t32", int'(bus.frame_sel), 2);
      if (i == 47) chk("frame_t48", int'(bus.frame_sel), 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
